// File: rtl/exp_requester_if.sv
// ---------------------------------------------------------------------------
// exp_requester_if
//   Bundles the signals between the exponential-engine requester, its
//   operand producer, the engine and the result consumer.
//
//   Handshake semantics (both valid/ready ports):
//     A transfer happens on a rising clock edge where valid and ready are both
//     high. The source holds valid and data stable until that transfer happens.
//     The sink may raise or lower ready at any time. ready may depend
//     combinationally on the state of the sink and on out_ready.
//
//   Signals:
//     in_valid / in_ready / in_data        operand input port
//     start / x_out                         request pulse and operand to engine
//     done / eng_result                     engine completion pulse and result
//     out_valid / out_ready / out_data      result output port
//     out_err                               result came from the watchdog
//     busy                                  request in flight
//
//   Modports:
//     master : the requester itself
//     slave  : the surrounding environment (producer, engine, consumer)
// ---------------------------------------------------------------------------
interface exp_requester_if #(
    parameter int DW = 16,
    parameter int RW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          start;
    logic [DW-1:0] x_out;
    logic          done;
    logic [RW-1:0] eng_result;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_err;
    logic          busy;

    modport master (
        input  in_valid, in_data, done, eng_result, out_ready,
        output in_ready, start, x_out, out_valid, out_data, out_err, busy
    );

    modport slave (
        output in_valid, in_data, done, eng_result, out_ready,
        input  in_ready, start, x_out, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/exp_requester.sv
// ---------------------------------------------------------------------------
// exp_requester
//   Host-side initiator for the iterative exponential engine. Takes one
//   operand, fires a single-cycle start pulse, waits for the engine's done
//   pulse (or a watchdog expiry) and presents the result in a one-entry
//   output register.
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous, active-high reset
//     bus      exp_requester_if.master (operand, engine and result signals)
//     state_o  current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT) for observation
//
//   Parameters:
//     DW       operand width
//     RW       result width
//     TIMEOUT  WAIT cycles before the request is abandoned with out_err
//              (intended to be at least 8)
// ---------------------------------------------------------------------------
module exp_requester #(
    parameter int DW      = 16,
    parameter int RW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    exp_requester_if.master    bus,
    output logic [1:0]         state_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] x_q, x_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic          out_err_q, out_err_d;

    logic          in_ready_c;
    logic          accept_c;
    logic          pop_c;
    logic          start_c;

    // A pop and a new accept may share a cycle: ready looks through out_ready.
    // Because new work is only taken when the output register will be empty,
    // a WAIT exit never finds the register still full.
    assign in_ready_c = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept_c   = in_ready_c && bus.in_valid;
    assign pop_c      = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        wcnt_d      = wcnt_q;
        out_valid_d = out_valid_q && !pop_c;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        start_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // done is deliberately ignored here (stray or late pulse).
                if (accept_c) begin
                    x_d     = bus.in_data;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_c = 1'b1;
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Saturate rather than wrap so the watchdog can never re-arm.
                if (wcnt_q != CW'(TIMEOUT)) begin
                    wcnt_d = wcnt_q + CW'(1);
                end
                // done takes priority over a coincident watchdog expiry.
                if (bus.done) begin
                    out_data_d  = bus.eng_result;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    out_data_d  = '0;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.start     = start_c;
    assign bus.x_out     = x_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign state_o       = state_q;
endmodule

// File: tb/tb_exp_requester.sv
// ---------------------------------------------------------------------------
// tb_exp_requester
//   Self-checking bench for exp_requester: behavioural engine model,
//   operand driver tasks, result scoreboard and a final summary line.
// ---------------------------------------------------------------------------
module tb_exp_requester;
    localparam int DW      = 16;
    localparam int RW      = 16;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- DUT ----------------
    exp_requester_if #(.DW(DW), .RW(RW)) bus ();
    logic [1:0] state_o;

    exp_requester #(.DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          eng_done = 1'b0;
    logic [RW-1:0] eng_res  = '0;
    logic          inj_done;
    logic [RW-1:0] inj_res;

    assign bus.in_valid   = in_valid;
    assign bus.in_data    = in_data;
    assign bus.out_ready  = out_ready;
    assign bus.done       = eng_done | inj_done;
    assign bus.eng_result = inj_done ? inj_res : eng_res;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // ---------------- engine model ----------------
    logic [RW-1:0] eng_q[$];
    int            eng_lat = 6;
    logic          eng_on  = 1'b1;

    initial begin : engine
        logic [DW-1:0] x_at;
        forever begin
            @(negedge clk);
            if (bus.start && eng_on && eng_q.size() > 0) begin
                x_at = bus.x_out;
                repeat (eng_lat) @(posedge clk);
                #1;
                eng_done = 1'b1;
                eng_res  = eng_q.pop_front();
                @(negedge clk);
                if (bus.busy) check_eq("x_out_stable", 32'(bus.x_out), 32'(x_at));
                @(posedge clk);
                #1;
                eng_done = 1'b0;
                eng_res  = '0;
            end
        end
    end

    // ---------------- start monitor ----------------
    int   start_cnt = 0;
    int   start_cyc[$];
    logic start_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (bus.start) begin
            start_cnt++;
            start_cyc.push_back(cyc);
            if (start_prev) check_eq("start_consecutive", 32'd1, 32'd0);
        end
        start_prev = bus.start;
    end

    // ---------------- scoreboard ----------------
    logic [RW:0] exp_q[$];

    initial begin : scoreboard
        logic [RW:0] e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 32'({bus.out_err, bus.out_data}), 32'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("result", 32'({bus.out_err, bus.out_data}), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call just after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [DW-1:0] d, output int t_acc);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t_acc    = cyc;
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    // Returns at the first falling edge with out_valid high.
    task automatic wait_out(input string tag, input int t_acc, input int exp_lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        else check_eq({tag, "_latency"}, 32'(cyc - t_acc), 32'(exp_lat));
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int            t;
        int            bad_rdy;
        int            bad_data;
        logic [DW-1:0] ops[4];
        logic [RW-1:0] res;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        inj_done  = 1'b0;
        inj_res   = '0;

        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy",      32'(bus.busy),      32'd0);
        check_eq("rst_start",     32'(bus.start),     32'd0);
        check_eq("rst_x_out",     32'(bus.x_out),     32'd0);
        check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("rst_out_err",   32'(bus.out_err),   32'd0);
        check_eq("rst_state",     32'(state_o),       32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Basic request, result left in the register for the backpressure test.
        @(posedge clk);
        #1;
        start_cnt = 0;
        eng_lat   = 6;
        eng_q.push_back(16'h02B8);
        exp_q.push_back({1'b0, 16'h02B8});
        send(16'h0100, t);
        wait_out("basic", t, 7);
        check_eq("basic_data",   32'(bus.out_data), 32'h02B8);
        check_eq("basic_err",    32'(bus.out_err),  32'd0);
        check_eq("basic_x_out",  32'(bus.x_out),    32'h0100);
        check_eq("basic_starts", 32'(start_cnt),    32'd1);

        // Backpressure with the next operand already waiting.
        in_valid = 1'b1;
        in_data  = 16'h0200;
        eng_q.push_back(16'h0333);
        exp_q.push_back({1'b0, 16'h0333});
        bad_rdy  = 0;
        bad_data = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.in_ready) bad_rdy++;
            if (bus.out_data !== 16'h02B8 || bus.out_valid !== 1'b1) bad_data++;
        end
        check_eq("bp_in_ready_low", 32'(bad_rdy),  32'd0);
        check_eq("bp_data_hold",    32'(bad_data), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_pop_accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t        = cyc;
        @(negedge clk);
        check_eq("bp_start_next", 32'(bus.start), 32'd1);
        wait_out("bp", t, 7);

        // Back-to-back with a 10-cycle engine.
        @(posedge clk);
        #1;
        eng_lat = 10;
        start_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            ops[k] = DW'($urandom_range(0, 16'hFFFF));
            res    = RW'($urandom_range(0, 16'hFFFF));
            eng_q.push_back(res);
            exp_q.push_back({1'b0, res});
        end
        for (int k = 0; k < 4; k++) send(ops[k], t);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("b2b_drained",     32'(exp_q.size()),     32'd0);
        check_eq("b2b_start_count", 32'(start_cyc.size()), 32'd4);
        for (int k = 1; k < 4; k++) begin
            if (start_cyc.size() > k)
                check_eq("b2b_start_gap", 32'(start_cyc[k] - start_cyc[k-1]), 32'd12);
        end

        // Watchdog expiry, then a late done that must be ignored.
        @(posedge clk);
        #1;
        eng_on = 1'b0;
        exp_q.push_back({1'b1, 16'h0000});
        send(16'h0055, t);
        wait_out("timeout", t, TIMEOUT + 1);
        check_eq("timeout_err",  32'(bus.out_err),  32'd1);
        check_eq("timeout_data", 32'(bus.out_data), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        inj_res  = 16'hBEEF;
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("late_done_no_valid", 32'(bus.out_valid), 32'd0);
        check_eq("late_done_idle",     32'(bus.busy),      32'd0);
        eng_on = 1'b1;

        // done lands in the same cycle the watchdog would fire.
        @(posedge clk);
        #1;
        eng_lat = TIMEOUT;
        eng_q.push_back(16'h1234);
        exp_q.push_back({1'b0, 16'h1234});
        send(16'h0077, t);
        wait_out("coinc", t, TIMEOUT + 1);
        check_eq("coinc_data", 32'(bus.out_data), 32'h1234);
        check_eq("coinc_err",  32'(bus.out_err),  32'd0);

        // Reset three cycles after start; the engine's done arrives afterwards.
        @(posedge clk);
        #1;
        eng_lat = 8;
        eng_q.push_back(16'h7777);
        send(16'h0099, t);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_busy",      32'(bus.busy),      32'd0);
        check_eq("mid_rst_start",     32'(bus.start),     32'd0);
        check_eq("mid_rst_x_out",     32'(bus.x_out),     32'd0);
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("mid_rst_out_err",   32'(bus.out_err),   32'd0);
        check_eq("mid_rst_state",     32'(state_o),       32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
        check_eq("post_rst_engine_q", 32'(eng_q.size()),  32'd0);

        // Normal request after the reset.
        @(posedge clk);
        #1;
        eng_lat = 6;
        eng_q.push_back(16'h4321);
        exp_q.push_back({1'b0, 16'h4321});
        send(16'h0042, t);
        wait_out("post_rst", t, 7);
        check_eq("post_rst_data", 32'(bus.out_data), 32'h4321);

        repeat (5) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/exp_requester.md
# exp_requester

Host-side initiator for the iterative exponential engine's start/done handshake. Accepts operands on a valid/ready input port, drives the engine's operand bus and single-cycle `start` pulse, and waits for the engine's `done` pulse. It then captures the result into a one-entry output register presented on a valid/ready output port. A watchdog terminates a request with an error flag if `done` never arrives.

## Interface
- `DW`, 16: operand width (`x` bus to engine).
- `RW`, 16: result width.
- `TIMEOUT`, 64: maximum WAIT-state cycles before error; legal range ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `in_valid`  in  1  operand available.
- `in_ready`  out  1  operand accepted when high with `in_valid`.
- `in_data`  in  DW  operand.
- `start`  out  1  single-cycle request pulse to engine.
- `x_out`  out  DW  operand to engine; stable from `start` until request completes.
- `done`  in  1  engine completion pulse.
- `eng_result`  in  RW  engine result; valid in the cycle `done` is high.
- `out_valid`  out  1  result register full.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  RW  captured result.
- `out_err`  out  1  result produced by timeout, not by engine.
- `busy`  out  1  request in flight (LAUNCH or WAIT).

## Operation
- States: IDLE, LAUNCH, WAIT.
- `in_ready` = (state == IDLE) && (!`out_valid` || `out_ready`). This is combinational, so a pop and a new accept in the same cycle are legal.
- IDLE:
  - On accept, `x_reg` ← `in_data`, then go to LAUNCH.
  - `done` is ignored in IDLE (stray or late pulse).
- LAUNCH: `start` = 1 for exactly this cycle. Watchdog `wcnt` ← 0. Next state is WAIT unconditionally. `done` is ignored in LAUNCH.
- WAIT:
  - `wcnt` increments each cycle.
  - If `done` = 1: `out_data` ← `eng_result`, `out_err` ← 0, `out_valid` ← 1, then go to IDLE.
  - Else if `wcnt` == `TIMEOUT`−1: `out_data` ← 0, `out_err` ← 1, `out_valid` ← 1, then go to IDLE.
  - If `done` and the timeout condition coincide, `done` wins and the real result is captured.
- Output register:
  - Clears `out_valid` on `out_valid` && `out_ready` unless refilled in the same cycle.
  - `out_data` and `out_err` hold while `out_valid` && !`out_ready`.
  - The output register is always empty on WAIT exit, guaranteed by the `in_ready` rule, so no overwrite case exists.
- `x_out` = `x_reg`, held until the next accept.
- `busy` = (state != IDLE).
- `wcnt` width is clog2(`TIMEOUT`+1) and `wcnt` saturates; no wrap-around is possible.
- Reset values (async, immediate): state IDLE, `start` 0, `x_reg`/`x_out` 0, `wcnt` 0, `out_valid` 0, `out_data` 0, `out_err` 0, `busy` 0.
  - `in_ready` is 1 once `rst` deasserts.
  - Reset mid-WAIT drops the request silently; a later engine `done` lands in IDLE and is ignored.

## Timing
- Accept at edge E0 → LAUNCH during E0..E1 (`start` = 1).
- The engine samples `start` at E1. Its earliest `done` is during E6..E7, using the minimum path Init, Begin, Mult1, Mult2, Add, setdone.
- Capture at E7 → `out_valid` = 1 from E7. Minimum input-to-output latency is 7 cycles.
- Timeout: `out_valid` rises `TIMEOUT`+1 cycles after the accept edge.
- Throughput: one request per (engine latency + 2) cycles with `out_ready` held high.
- `start` never asserts in two consecutive cycles, and never asserts outside LAUNCH.

## Test plan
- Basic request:
  - Stimulus: `in_data`=0x0100; behavioural engine model returns 0x02B8 with `done` 6 cycles after `start`.
  - Required: exactly one `start` pulse; `x_out`=0x0100 stable; `out_valid` at accept+7; `out_data`=0x02B8; `out_err`=0.
- Backpressure:
  - Stimulus: `out_ready`=0 for 20 cycles after result.
  - Required: `out_data` holds 0x02B8; `in_ready`=0 throughout.
  - When `out_ready` rises with `in_valid` high, pop and accept occur in the same cycle; next `start` follows 1 cycle later.
- Back-to-back:
  - Stimulus: 4 operands with `out_ready`=1 and a 10-cycle engine.
  - Required: 4 results in order; each `start` spaced 12 cycles apart; no `out_err`.
- Timeout:
  - Stimulus: `TIMEOUT`=16; engine never asserts `done`.
  - Required: `out_valid` at accept+17 with `out_err`=1 and `out_data`=0.
  - A `done` injected 5 cycles later is ignored (no second `out_valid`).
- Coincidence:
  - Stimulus: `done` asserted exactly in the cycle `wcnt`=`TIMEOUT`−1, with `eng_result`=0x1234.
  - Required: `out_data`=0x1234 and `out_err`=0.
- Reset mid-WAIT:
  - Stimulus: assert `rst` 3 cycles after `start`.
  - Required: all outputs go to reset values immediately without a clock edge; a subsequent `done` pulse produces no `out_valid`; the next request completes normally.
